ifetch_seq: RTL
===============

# ifetch_seq

Instruction fetch sequencer sitting directly downstream of the 8-bit program counter register in the MIPS datapath. It takes the current PC and reads four consecutive bytes from a byte-wide, synchronous instruction memory. It assembles them big-endian into a 32-bit instruction and presents it with a one-cycle valid strobe. In the same cycle it pulses `pc_advance`, which the PC register uses as its load enable.

## Interface
- `ADDR_W`, default 8: PC and memory address width.
- `BYTE_W`, default 8: memory data width.
- `INSTR_W`, default 32: assembled instruction width; always 4 × `BYTE_W`.
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst`, input, 1: reset; asynchronous, active-high.
- `pc`, input, `ADDR_W`: current PC from the PC register.
- `fetch_req`, input, 1: request to fetch the instruction at `pc`.
- `redirect`, input, 1: branch/jump flush; aborts the fetch in progress.
- `mem_addr`, output, `ADDR_W`: instruction memory byte address.
- `mem_rd`, output, 1: memory read strobe.
- `mem_rdata`, input, `BYTE_W`: read data, valid in the cycle after `mem_rd`.
- `instr`, output, `INSTR_W`: last completed instruction.
- `instr_valid`, output, 1: `instr` is newly valid; one-cycle pulse.
- `pc_advance`, output, 1: PC load enable; one-cycle pulse.
- `busy`, output, 1: high whenever the sequencer is not in IDLE.
- `align_fault`, output, 1: misaligned PC detected; one-cycle pulse.

## Operation
- **States:** IDLE, FETCH, LAST, DONE.
- **IDLE:**
  - On `fetch_req=1` and `redirect=0`, latch `pc` into `base`, clear `beat`, and go to FETCH.
  - Otherwise stay in IDLE.
- **FETCH:**
  - Drive `mem_rd=1` and `mem_addr = base + beat`; the addition is modulo 2^`ADDR_W`, so addresses wrap.
  - Increment `beat` each cycle.
  - After the cycle with `beat=3`, go to LAST.
- **Byte capture:** every cycle following a `mem_rd`, shift `mem_rdata` into the assembly register. Beat 0 lands in `instr[31:24]` and beat 3 in `instr[7:0]`.
- **LAST:** `mem_rd=0`. Capture beat 3, load `instr` from the assembly register, and go to DONE.
- **DONE:**
  - Assert `instr_valid=1` and `pc_advance=1`.
  - Go to IDLE unconditionally; the PC is not updated until the end of this cycle.
- **`redirect`:**
  - In FETCH or LAST: next state is IDLE; no `instr_valid` or `pc_advance` is produced, in-flight read data is discarded, and `instr` is unchanged.
  - In DONE: ignored, because the instruction is already committed.
  - In IDLE: blocks acceptance of `fetch_req` that cycle.
- **Outputs:**
  - `instr` holds its value until the next DONE.
  - `busy = (state != IDLE)`.
  - `mem_addr` is 0 whenever `mem_rd=0`.

## Timing
- **Reset values:** state IDLE; `instr=0`, `instr_valid=0`, `pc_advance=0`, `mem_rd=0`, `mem_addr=0`, `busy=0`, `align_fault=0`.
- **Latency:** with `fetch_req` sampled in IDLE in cycle N:
  - `mem_rd` is high in cycles N+1 to N+4.
  - The sequencer is in LAST in N+5.
  - `instr_valid` and `pc_advance` are high in N+6.
  - IDLE is re-entered in N+7.
- **Throughput:** the minimum period is 7 cycles per instruction, with `fetch_req` held high.
- **Reset mid-fetch:** returns immediately to the reset values; no partial instruction ever appears on `instr`.
- **`redirect` timing:** `redirect` sampled in cycle M (FETCH or LAST) gives `busy=0` in M+1.

## Configuration
- **Macro `IFETCH_ALIGN_CHECK_EN` defined:**
  - In IDLE, `fetch_req=1` with `pc[1:0]!=0` does not start a fetch.
  - `align_fault` pulses in the next cycle and the sequencer stays in IDLE.
  - No `mem_rd` and no `pc_advance` are produced.
- **Macro undefined:** `align_fault` is tied to 0 and any PC value is fetched.

## Structure
- **Shared package `ifetch_pkg`:**
  - the state enum (IDLE, FETCH, LAST, DONE);
  - `BEATS=4`;
  - the 2-bit `beat` counter width.
- **Sub-module `byte_assembler`:**
  - A 4-deep byte shift register with a capture enable and a synchronous clear.
  - It is the only sub-module; the FSM, address generation and output register stay in `ifetch_seq`.

## Test plan
The memory model returns `mem[a] = a` with 1-cycle read latency.
- **Basic fetch:** `pc=0x10`, `fetch_req` pulse in cycle N → `mem_addr` 0x10, 0x11, 0x12, 0x13 in N+1 to N+4; `instr=0x10111213`, `instr_valid` and `pc_advance` high only in N+6.
- **Wrap-around:** `pc=0xFC` → addresses 0xFC to 0xFF, `instr=0xFCFDFEFF`. With the macro undefined, `pc=0xFE` → addresses FE, FF, 00, 01 and `instr=0xFEFF0001`.
- **Flush:** after completing 0x10111213, start a fetch at `pc=0x20` and assert `redirect` in N+3 → `busy=0` in N+4, no `instr_valid`, `instr` stays 0x10111213.
- **Back-to-back:** hold `fetch_req=1`; the bench adds 4 to `pc` on `pc_advance`, starting from 0x00 → `instr` = 0x00010203, 0x04050607, 0x08090A0B, with `instr_valid` exactly 7 cycles apart.
- **Async reset:** assert `rst` between clock edges in cycle N+2 of a fetch → all outputs return to their reset values immediately (`instr=0`, `busy=0`); the next fetch after reset release behaves as the basic fetch.
- **Misaligned PC:** `pc=0x05`. With `IFETCH_ALIGN_CHECK_EN` defined → `align_fault` high in N+1, no `mem_rd`, `busy=0`. Without the macro → `instr=0x05060708`.

Source files
------------

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared state encoding and beat constants for the fetch sequencer
package ifetch_pkg;

    localparam int BEATS  = 4;
    localparam int BEAT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LAST  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ifetch_seq_if.sv
// rtl/ifetch_seq_if.sv - PC/fetch control, byte memory and instruction result bundle
interface ifetch_seq_if #(
    parameter int ADDR_W = 8,
    parameter int BYTE_W = 8
);
    localparam int INSTR_W = 4 * BYTE_W;

    logic [ADDR_W-1:0]  pc;
    logic               fetch_req;
    logic               redirect;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd;
    logic [BYTE_W-1:0]  mem_rdata;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               pc_advance;
    logic               busy;
    logic               align_fault;

    modport slave (
        input  pc, fetch_req, redirect, mem_rdata,
        output mem_addr, mem_rd, instr, instr_valid, pc_advance, busy, align_fault
    );

    modport master (
        output pc, fetch_req, redirect, mem_rdata,
        input  mem_addr, mem_rd, instr, instr_valid, pc_advance, busy, align_fault
    );

endinterface

// File: rtl/ifetch_seq_byte_assembler.sv
// rtl/ifetch_seq_byte_assembler.sv - 4-deep byte shift register; first byte ends up most significant
module byte_assembler #(
    parameter int BYTE_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    cap_i,
    input  logic [BYTE_W-1:0]       byte_i,
    output logic [DEPTH*BYTE_W-1:0] data_o
);

    logic [DEPTH*BYTE_W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (clr_i) begin
            data_q <= '0;
        end else if (cap_i) begin
            data_q <= {data_q[(DEPTH-1)*BYTE_W-1:0], byte_i};
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/ifetch_seq.sv
// rtl/ifetch_seq.sv - four-beat big-endian instruction fetch FSM; IFETCH_ALIGN_CHECK_EN rejects misaligned PCs
module ifetch_seq
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int BYTE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    ifetch_seq_if.slave bus
);

    localparam int INSTR_W = BEATS * BYTE_W;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               rd_q;
    logic               start;
    logic               mem_rd;
    logic               asm_cap;
    logic               misaligned;
    logic [INSTR_W-1:0] asm_data;
    logic               unused_asm_msb;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic align_fault_q;

    assign misaligned = (bus.pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_fault_q <= 1'b0;
        end else begin
            align_fault_q <= (state_q == IDLE) && bus.fetch_req && !bus.redirect && misaligned;
        end
    end

    assign bus.align_fault = align_fault_q;
`else
    assign misaligned      = 1'b0;
    assign bus.align_fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            beat_q  <= '0;
            instr_q <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            instr_q <= instr_d;
            rd_q    <= mem_rd;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        beat_d  = beat_q;
        instr_d = instr_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.fetch_req && !bus.redirect && !misaligned) begin
                    start   = 1'b1;
                    base_d  = bus.pc;
                    beat_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                beat_d = beat_q + 1'b1;
                if (bus.redirect) begin
                    state_d = IDLE;
                end else if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = LAST;
                end
            end
            LAST: begin
                // Beat 3 is still on the memory bus, so it is merged in directly.
                if (bus.redirect) begin
                    state_d = IDLE;
                end else begin
                    instr_d = {asm_data[INSTR_W-BYTE_W-1:0], bus.mem_rdata};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reads still in flight after a flush land while IDLE and are dropped here.
    assign asm_cap = rd_q && ((state_q == FETCH) || (state_q == LAST));

    byte_assembler #(
        .BYTE_W (BYTE_W),
        .DEPTH  (BEATS)
    ) u_asm (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start),
        .cap_i  (asm_cap),
        .byte_i (bus.mem_rdata),
        .data_o (asm_data)
    );

    assign unused_asm_msb = ^asm_data[INSTR_W-1 -: BYTE_W];

    assign mem_rd          = (state_q == FETCH);
    assign bus.mem_rd      = mem_rd;
    assign bus.mem_addr    = mem_rd ? (base_q + ADDR_W'(beat_q)) : '0;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state_q == DONE);
    assign bus.pc_advance  = (state_q == DONE);
    assign bus.busy        = (state_q != IDLE);

endmodule
